ntt_sequencer: RTL

- Top-level run controller for the 256-point NTT engine. Sequences the address generator through three phases: one load pass (IN), LAYERS compute passes (NTT or INTT), and one unload pass (OUT).
- Drives the address generator's mode and newloop inputs and arbitrates coefficient-RAM ownership between the HPS host and the engine.
- Gives the host a start/done handshake with abort.

---
 rtl/ntt_sequencer_if.sv | 28 ++
 rtl/ntt_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_sequencer_if.sv
// Host/engine handshake bundle for the NTT run sequencer.
// The slave side is the sequencer itself; the master side is the HPS host
// (control inputs) which also observes the address-generator controls.
interface ntt_sequencer_if;
  logic        start;
  logic        op;
  logic        load_en;
  logic        unload_en;
  logic        abort;
  logic [1:0]  mode;
  logic        newloop;
  logic [2:0]  layer_idx;
  logic [1:0]  phase;
  logic        mem_owner;
  logic        busy;
  logic        done;
  logic [23:0] cycle_count;

  modport master (
    output start, op, load_en, unload_en, abort,
    input  mode, newloop, layer_idx, phase, mem_owner, busy, done, cycle_count
  );

  modport slave (
    input  start, op, load_en, unload_en, abort,
    output mode, newloop, layer_idx, phase, mem_owner, busy, done, cycle_count
  );
endinterface

// File: rtl/ntt_sequencer.sv
// Run controller for the 256-point NTT engine: one optional load pass,
// LAYERS compute passes and one optional unload pass, each opened by a
// single-cycle newloop pulse to the address generator. Also hands the
// coefficient RAMs between host and engine.
//
// Optional build macro NTT_SEQ_PERF_CNT_EN: adds a 24-bit run-length
// counter reported on cycle_count after each completed run. Without it
// cycle_count is constant zero.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for start, host owns RAMs
// LOAD_NL  | newloop pulse for the load pass (mode IN)
// LOAD_RUN | load pass in progress
// COMP_NL  | newloop pulse for compute layer layer_idx
// COMP_RUN | compute layer in progress (mode NTT/INTT)
// UNLD_NL  | newloop pulse for the unload pass (mode OUT)
// UNLD_RUN | unload pass in progress
// DONE     | one-cycle completion pulse, RAMs back to host
module ntt_sequencer #(
  parameter int LAYERS          = 7,
  parameter int NTT_PASS_CYCLES = 1000,
  parameter int IO_PASS_CYCLES  = 272,
  parameter int TIMER_W         = 16
) (
  input  logic            clk,
  input  logic            rst,
  ntt_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_NL,
    LOAD_RUN,
    COMP_NL,
    COMP_RUN,
    UNLD_NL,
    UNLD_RUN,
    DONE
  } state_t;

  localparam logic [TIMER_W-1:0] IO_LAST    = TIMER_W'(IO_PASS_CYCLES - 1);
  localparam logic [TIMER_W-1:0] NTT_LAST   = TIMER_W'(NTT_PASS_CYCLES - 1);
  localparam logic [2:0]         LAYER_LAST = 3'(LAYERS - 1);

  localparam logic [1:0] MODE_IN  = 2'b10;
  localparam logic [1:0] MODE_OUT = 2'b11;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_LOAD = 2'd1;
  localparam logic [1:0] PH_COMP = 2'd2;
  localparam logic [1:0] PH_UNLD = 2'd3;

  state_t               state_q, state_nxt;
  logic [TIMER_W-1:0]   timer_q, timer_nxt;
  logic [2:0]           layer_q, layer_nxt;
  logic                 op_q, op_nxt;
  logic                 load_q, load_nxt;
  logic                 unload_q, unload_nxt;

  // Output registers; they are loaded from the decode of the state being
  // entered so every output changes on the same edge as the state.
  logic [1:0]           mode_q, mode_nxt;
  logic                 newloop_q, newloop_nxt;
  logic [1:0]           phase_q, phase_nxt;
  logic                 owner_q, owner_nxt;
  logic                 busy_q, busy_nxt;
  logic                 done_q, done_nxt;

  // Next-state, pass timer, layer counter and run-configuration latch.
  always_comb begin
    state_nxt  = state_q;
    timer_nxt  = '0;
    layer_nxt  = layer_q;
    op_nxt     = op_q;
    load_nxt   = load_q;
    unload_nxt = unload_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          op_nxt     = bus.op;
          load_nxt   = bus.load_en;
          unload_nxt = bus.unload_en;
          state_nxt  = bus.load_en ? LOAD_NL : COMP_NL;
        end
      end
      LOAD_NL: state_nxt = LOAD_RUN;
      LOAD_RUN: begin
        if (timer_q == IO_LAST) begin
          state_nxt = COMP_NL;
        end else begin
          timer_nxt = timer_q + TIMER_W'(1);
        end
      end
      COMP_NL: state_nxt = COMP_RUN;
      COMP_RUN: begin
        if (timer_q == NTT_LAST) begin
          if (layer_q < LAYER_LAST) begin
            layer_nxt = layer_q + 3'd1;
            state_nxt = COMP_NL;
          end else begin
            layer_nxt = '0;
            state_nxt = unload_q ? UNLD_NL : DONE;
          end
        end else begin
          timer_nxt = timer_q + TIMER_W'(1);
        end
      end
      UNLD_NL: state_nxt = UNLD_RUN;
      UNLD_RUN: begin
        if (timer_q == IO_LAST) begin
          state_nxt = DONE;
        end else begin
          timer_nxt = timer_q + TIMER_W'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Abort overrides everything outside IDLE; a run caught in DONE still
    // shows its done pulse because done_q already reflects this cycle.
    if (bus.abort && state_q != IDLE) begin
      state_nxt = IDLE;
      layer_nxt = '0;
      timer_nxt = '0;
    end
  end

  // Output decode for the state being entered.
  always_comb begin
    mode_nxt    = MODE_IN;
    newloop_nxt = 1'b0;
    phase_nxt   = PH_IDLE;
    owner_nxt   = 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == DONE);

    case (state_nxt)
      LOAD_NL: begin
        newloop_nxt = 1'b1;
        phase_nxt   = PH_LOAD;
        owner_nxt   = 1'b1;
      end
      LOAD_RUN: begin
        phase_nxt = PH_LOAD;
        owner_nxt = 1'b1;
      end
      COMP_NL: begin
        mode_nxt    = {1'b0, op_nxt};
        newloop_nxt = 1'b1;
        phase_nxt   = PH_COMP;
        owner_nxt   = 1'b1;
      end
      COMP_RUN: begin
        mode_nxt  = {1'b0, op_nxt};
        phase_nxt = PH_COMP;
        owner_nxt = 1'b1;
      end
      UNLD_NL: begin
        mode_nxt    = MODE_OUT;
        newloop_nxt = 1'b1;
        phase_nxt   = PH_UNLD;
        owner_nxt   = 1'b1;
      end
      UNLD_RUN: begin
        mode_nxt  = MODE_OUT;
        phase_nxt = PH_UNLD;
        owner_nxt = 1'b1;
      end
      default: begin
        mode_nxt = MODE_IN;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      layer_q   <= '0;
      op_q      <= 1'b0;
      load_q    <= 1'b0;
      unload_q  <= 1'b0;
      mode_q    <= MODE_IN;
      newloop_q <= 1'b0;
      phase_q   <= PH_IDLE;
      owner_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      timer_q   <= timer_nxt;
      layer_q   <= layer_nxt;
      op_q      <= op_nxt;
      load_q    <= load_nxt;
      unload_q  <= unload_nxt;
      mode_q    <= mode_nxt;
      newloop_q <= newloop_nxt;
      phase_q   <= phase_nxt;
      owner_q   <= owner_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.mode      = mode_q;
  assign bus.newloop   = newloop_q;
  assign bus.layer_idx = layer_q;
  assign bus.phase     = phase_q;
  assign bus.mem_owner = owner_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef NTT_SEQ_PERF_CNT_EN
  logic        accept;
  logic [23:0] perf_q;
  logic [23:0] perf_inc;
  logic [23:0] cc_q;

  assign accept   = (state_q == IDLE) && bus.start && !bus.abort;
  assign perf_inc = (perf_q == 24'hFFFFFF) ? perf_q : perf_q + 24'd1;

  // The counter already includes the busy cycle being entered, so the value
  // copied on entry to DONE counts the DONE cycle itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
      cc_q   <= '0;
    end else begin
      if (accept) begin
        perf_q <= 24'd1;
      end else if (state_nxt != IDLE) begin
        perf_q <= perf_inc;
      end
      if (state_nxt == DONE && state_q != DONE) begin
        cc_q <= perf_inc;
      end
    end
  end

  assign bus.cycle_count = cc_q;
`else
  assign bus.cycle_count = '0;
`endif

endmodule
